// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: register address
//   width, bypass-mux encodings, divider FSM states, the asserted reset level
//   and the register-match helper (register $0 never matches).
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REGADDR = 5;
  typedef logic [REGADDR-1:0] regaddr_t;

  // Bypass mux select for the E-stage operands
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // Level of the reset port that holds the block in reset
  localparam logic RESETABLE = 1'b0;

  function automatic logic reg_match(input regaddr_t dst, input regaddr_t src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_div_stall_timer.sv
// div_stall_timer
//   Holds the pipe for a multi-cycle DIV/MULT op. The start cycle itself
//   stalls, then DIV_CYCLES-1 BUSY cycles follow, then a one-cycle DONE in
//   which E advances. An abort (exception in M) returns to IDLE at once.
// Ports
//   clock    in   posedge clock
//   reset    in   asynchronous, active-low
//   start    in   DIV/MULT op present in E
//   abort    in   exception committed in M
//   busy     out  registered, 1 while in BUSY
//   done     out  registered, 1-cycle pulse on completion
//   divstall out  combinational stall request
module div_stall_timer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic divstall
);

  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 2);

  div_state_t state;
  logic [5:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESETABLE) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        DONE: begin
          // A start seen here is taken one cycle later, from IDLE.
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    divstall = ((state == IDLE) && start) || (state == BUSY);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush/forward controller for the 5-stage MIPS pipeline, plus the
//   DIV/MULT stall timer. Build option HAZARD_FWD_EN enables the bypass
//   network; without it every Forward* output is 0 and any D-source match
//   against a writing E or M destination stalls F/D and flushes E.
// Ports
//   clock, reset                 clock, async active-low reset
//   RsD/RtD, RsE/RtE             source registers in D and E
//   WriteRegE/M/W, RegWriteE/M/W destination and write enable per stage
//   MemtoRegE/M                  load in E/M
//   BranchD, PCSrcD              branch in D, branch taken
//   DivStartE, ExcM              DIV/MULT in E, exception in M
//   StallF/D/E, FlushD/E/M       pipeline register controls
//   ForwardAD/BD, ForwardAE/BE   bypass mux selects in D and E
//   DivBusy, DivDone             registered divider status
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [4:0]     RsD,
  input  logic [4:0]     RtD,
  input  logic [4:0]     RsE,
  input  logic [4:0]     RtE,
  input  logic [4:0]     WriteRegE,
  input  logic [4:0]     WriteRegM,
  input  logic [4:0]     WriteRegW,
  input  logic           RegWriteE,
  input  logic           RegWriteM,
  input  logic           RegWriteW,
  input  logic           MemtoRegE,
  input  logic           MemtoRegM,
  input  logic           BranchD,
  input  logic           PCSrcD,
  input  logic           DivStartE,
  input  logic           ExcM,
  output logic           StallF,
  output logic           StallD,
  output logic           StallE,
  output logic           FlushD,
  output logic           FlushE,
  output logic           FlushM,
  output logic           ForwardAD,
  output logic           ForwardBD,
  output logic [1:0]     ForwardAE,
  output logic [1:0]     ForwardBE,
  output logic           DivBusy,
  output logic           DivDone
);

  logic divstall;
  logic datastall;
  logic e_hits_d;
  logic m_hits_d;

  div_stall_timer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_stall_timer (
    .clock    (clock),
    .reset    (reset),
    .start    (DivStartE),
    .abort    (ExcM),
    .busy     (DivBusy),
    .done     (DivDone),
    .divstall (divstall)
  );

  always_comb begin
    e_hits_d = reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD);
    m_hits_d = reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD);
`ifdef HAZARD_FWD_EN
    // lwstall | brstall
    datastall = (MemtoRegE && RegWriteE && e_hits_d) ||
                (BranchD && ((RegWriteE && e_hits_d) || (MemtoRegM && m_hits_d)));
`else
    datastall = (RegWriteE && e_hits_d) || (RegWriteM && m_hits_d);
`endif
  end

`ifndef HAZARD_FWD_EN
  logic unused_nofwd;
  assign unused_nofwd = ^{RsE, RtE, WriteRegW, RegWriteW, MemtoRegE, MemtoRegM, BranchD};
`endif

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reset != RESETABLE) begin
      // FlushD is only reachable on the branch where StallD stays 0.
      if (ExcM) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushM = 1'b1;
      end else if (divstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (datastall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (PCSrcD) begin
        FlushD = 1'b1;
      end
`ifdef HAZARD_FWD_EN
      ForwardAD = RegWriteM && reg_match(WriteRegM, RsD);
      ForwardBD = RegWriteM && reg_match(WriteRegM, RtD);
      if (RegWriteM && reg_match(WriteRegM, RsE))      ForwardAE = FWD_MEM;
      else if (RegWriteW && reg_match(WriteRegW, RsE)) ForwardAE = FWD_WB;
      if (RegWriteM && reg_match(WriteRegM, RtE))      ForwardBE = FWD_MEM;
      else if (RegWriteW && reg_match(WriteRegW, RtE)) ForwardBE = FWD_WB;
`endif
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int DIV = 32;

  // fl = {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD, DivStartE, ExcM}
  typedef struct packed {
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic [8:0] fl;
  } in_t;

  // ef: expected with forwarding built in, en: expected without
  typedef struct {
    in_t         vi;
    logic [11:0] ef;
    logic [11:0] en;
  } vec_t;

  logic clock, reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, PCSrcD, DivStartE, ExcM;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic DivBusy, DivDone;
  logic [11:0] outv;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_hazard_ctrl #(.DIV_CYCLES(DIV)) dut (
    .clock(clock), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .DivStartE(DivStartE), .ExcM(ExcM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .DivBusy(DivBusy), .DivDone(DivDone)
  );

  assign outv = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                 ForwardAD, ForwardBD, ForwardAE, ForwardBE};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    RsD = x.rsd; RtD = x.rtd; RsE = x.rse; RtE = x.rte;
    WriteRegE = x.wre; WriteRegM = x.wrm; WriteRegW = x.wrw;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
     BranchD, PCSrcD, DivStartE, ExcM} = x.fl;
  endtask

  function automatic in_t vin(input logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw,
                              input logic [8:0] fl);
    in_t v;
    v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte;
    v.wre = wre; v.wrm = wrm; v.wrw = wrw; v.fl = fl;
    return v;
  endfunction

  // ---------------- behavioural reference ----------------
  function automatic bit hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] src_sel(input in_t x, input logic [4:0] src);
    if (x.fl[7] && hit(x.wrm, src)) return 2'b10;
    if (x.fl[6] && hit(x.wrw, src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] ref_out(input in_t x, input bit busy, input bit idle);
    bit dE, mM, hz, ds;
    logic [11:0] r;
    dE = x.fl[8] && (hit(x.wre, x.rsd) || hit(x.wre, x.rtd));
    mM = hit(x.wrm, x.rsd) || hit(x.wrm, x.rtd);
    r  = '0;
`ifdef HAZARD_FWD_EN
    hz = (x.fl[5] && dE) || (x.fl[3] && (dE || (x.fl[4] && mM)));
    r[5]   = x.fl[7] && hit(x.wrm, x.rsd);
    r[4]   = x.fl[7] && hit(x.wrm, x.rtd);
    r[3:2] = src_sel(x, x.rse);
    r[1:0] = src_sel(x, x.rte);
`else
    hz = dE || (x.fl[7] && mM);
`endif
    ds = busy || (idle && x.fl[1]);
    if (x.fl[0])     r[8:6] = 3'b111;
    else if (ds)     begin r[11:9] = 3'b111; r[6] = 1'b1; end
    else if (hz)     begin r[11:10] = 2'b11; r[7] = 1'b1; end
    else if (x.fl[2]) r[8] = 1'b1;
    return r;
  endfunction

  vec_t tbl[$];
  in_t  zero_in;
  in_t  x;
  int   cnt;
  bit   fm_ok;
  int   rem;
  bit   mdone;

  initial begin
    zero_in = '0;
    drive(zero_in);
    PCSrcD = 1'b1;          // must be masked while in reset
    RegWriteM = 1'b1; WriteRegM = 5'd4; RsE = 5'd4;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("reset_outputs", {2'b00, outv}, 14'd0);
    check("reset_status", 14'({DivBusy, DivDone}), 14'd0);
    @(negedge clock);
    drive(zero_in);
    reset = 1'b1;

    // ---------------- table vectors ----------------
    tbl.push_back('{vin(0,0,0,0,0,0,0, 9'b000000000), 12'b000000000000, 12'b000000000000});
    tbl.push_back('{vin(8,0,0,0,8,0,0, 9'b100100000), 12'b110010000000, 12'b110010000000});
    tbl.push_back('{vin(0,0,8,0,0,0,8, 9'b001000000), 12'b000000000100, 12'b000000000000});
    tbl.push_back('{vin(0,0,9,0,0,9,9, 9'b011000000), 12'b000000001000, 12'b000000000000});
    tbl.push_back('{vin(0,0,0,0,0,0,0, 9'b011000000), 12'b000000000000, 12'b000000000000});
    tbl.push_back('{vin(0,7,0,0,7,0,0, 9'b100100100), 12'b110010000000, 12'b110010000000});
    tbl.push_back('{vin(0,0,0,0,0,0,0, 9'b000000100), 12'b000100000000, 12'b000100000000});
    tbl.push_back('{vin(0,7,0,0,7,0,0, 9'b100100111), 12'b000111000000, 12'b000111000000});
    tbl.push_back('{vin(5,0,0,0,0,5,0, 9'b010000000), 12'b000000100000, 12'b110010000000});
    tbl.push_back('{vin(0,12,0,0,12,0,0, 9'b100001000), 12'b110010000000, 12'b110010000000});
    tbl.push_back('{vin(3,0,0,0,0,3,0, 9'b010011000), 12'b110010100000, 12'b110010000000});
    tbl.push_back('{vin(0,4,0,0,0,4,0, 9'b010001000), 12'b000000010000, 12'b110010000000});
    tbl.push_back('{vin(0,0,0,6,0,6,6, 9'b001000000), 12'b000000000001, 12'b000000000000});
    tbl.push_back('{vin(0,0,0,0,0,0,0, 9'b100100000), 12'b000000000000, 12'b000000000000});
    tbl.push_back('{vin(6,0,0,0,0,0,6, 9'b001000000), 12'b000000000000, 12'b000000000000});
    tbl.push_back('{vin(0,0,2,3,0,2,3, 9'b011000000), 12'b000000001001, 12'b000000000000});

    foreach (tbl[i]) begin
      @(negedge clock);
      drive(tbl[i].vi);
      #1;
`ifdef HAZARD_FWD_EN
      check($sformatf("vec%0d", i), {2'b00, outv}, {2'b00, tbl[i].ef});
`else
      check($sformatf("vec%0d", i), {2'b00, outv}, {2'b00, tbl[i].en});
`endif
    end

    // ---------------- DIV: exact stall length, DONE pulse ----------------
    @(negedge clock);
    drive(zero_in);
    DivStartE = 1'b1;
    #1;
    cnt = 0;
    fm_ok = 1'b1;
    for (int i = 0; i < 100 && StallE; i++) begin
      cnt++;
      if (!FlushM || !StallF || !StallD || FlushD || FlushE) fm_ok = 1'b0;
      @(negedge clock);
      #1;
    end
    check("div_stall_len", 14'(cnt), 14'(DIV));
    check("div_flushm_held", 14'(fm_ok), 14'd1);
    check("div_done_pulse", 14'({DivDone, DivBusy, StallE}), 14'b100);
    @(negedge clock);
    DivStartE = 1'b0;
    #1;
    check("div_done_clear", 14'({DivDone, DivBusy, StallE}), 14'd0);

    // ---------------- DIV aborted by exception ----------------
    @(negedge clock);
    DivStartE = 1'b1;
    repeat (10) @(negedge clock);
    ExcM = 1'b1;
    PCSrcD = 1'b1;
    #1;
    check("exc_outputs", {2'b00, outv}, 14'b00_000111000000);
    check("exc_busy_before", 14'(DivBusy), 14'd1);
    @(posedge clock);
    #1;
    check("exc_busy_after", 14'({DivBusy, DivDone}), 14'd0);
    @(negedge clock);
    drive(zero_in);
    #1;
    check("exc_idle", {2'b00, outv}, 14'd0);

    // ---------------- async reset mid-BUSY ----------------
    @(negedge clock);
    DivStartE = 1'b1;
    repeat (5) @(negedge clock);
    RsD = 5'd8; WriteRegE = 5'd8; RegWriteE = 1'b1; MemtoRegE = 1'b1;
    #2;
    check("rst_busy_before", 14'(DivBusy), 14'd1);
    reset = 1'b0;
    #1;
    check("rst_async_status", 14'({DivBusy, DivDone}), 14'd0);
    check("rst_async_outputs", {2'b00, outv}, 14'd0);
    @(negedge clock);
    drive(zero_in);
    reset = 1'b1;
    #1;
    check("rst_release_idle", 14'({outv, DivBusy, DivDone}), 14'd0);

    // ---------------- randomized against the reference ----------------
    rem = 0;
    mdone = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      x.rsd = 5'($urandom_range(0, 3));
      x.rtd = 5'($urandom_range(0, 3));
      x.rse = 5'($urandom_range(0, 3));
      x.rte = 5'($urandom_range(0, 3));
      x.wre = 5'($urandom_range(0, 3));
      x.wrm = 5'($urandom_range(0, 3));
      x.wrw = 5'($urandom_range(0, 3));
      x.fl  = 9'($urandom);
      x.fl[1] = ($urandom_range(0, 11) == 0);
      x.fl[0] = ($urandom_range(0, 19) == 0);
      drive(x);
      #1;
      check($sformatf("rnd%0d_out", c), {2'b00, outv},
            {2'b00, ref_out(x, rem > 0, (rem == 0) && !mdone)});
      check($sformatf("rnd%0d_status", c), 14'({DivBusy, DivDone}),
            14'({rem > 0, mdone}));
      @(posedge clock);
      // stall cycles remaining after the current one; mdone = completion cycle
      if (x.fl[0]) begin
        rem = 0;
        mdone = 1'b0;
      end else if (rem > 0) begin
        rem--;
        mdone = (rem == 0);
      end else if (!mdone && x.fl[1]) begin
        rem = DIV - 1;
      end else begin
        mdone = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
